// File: rtl/simon_byte_engine.sv
// Iterative Simon block cipher with byte-serial key/block load and byte-serial result.
// Build option: define SIMON_DECRYPT_EN to add the decrypt path (KEYFWD, inverse key step, block swap).
module simon_byte_engine #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_is_key,
  input  logic       in_decrypt,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  if (!((N == 16 && M == 4) || ((N == 24 || N == 32) && (M == 3 || M == 4)))) begin : g_illegal_cfg
    $error("simon_byte_engine: illegal N/M combination");
  end

  localparam int unsigned KW = M * N;
  localparam int unsigned BW = 2 * N;
  localparam int unsigned R  = (N == 16) ? 32 : (N == 24) ? 36 : (M == 3) ? 42 : 44;
  localparam logic [3:0] BLAST = 4'(BW / 8 - 1);
  localparam logic [5:0] RLAST = 6'(R - 1);

  // Sequences are written z[0] first; reversed so that ZSEQ[i] == z[i].
  function automatic logic [61:0] zrev(input logic [61:0] s);
    logic [61:0] r;
    for (int unsigned i = 0; i < 62; i++) r[i] = s[61 - i];
    return r;
  endfunction

  localparam logic [61:0] Z0 = zrev(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [61:0] Z1 = zrev(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [61:0] Z2 = zrev(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = zrev(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [61:0] ZSEQ = (N == 16) ? Z0 : (N == 24) ? ((M == 3) ? Z0 : Z1) : ((M == 3) ? Z2 : Z3);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return rol(v, N - s);
  endfunction

  function automatic logic [N-1:0] kt(input logic [N-1:0] hi, input logic [N-1:0] lo);
    logic [N-1:0] a;
    a = ror(hi, 3) ^ ((M == 4) ? lo : '0);
    return a ^ ror(a, 1);
  endfunction

  // One-hot-ish encoding so in_ready/out_valid/busy are plain state bits.
  typedef enum logic [3:0] {
    LOAD   = 4'b0001,
    OUT    = 4'b0010,
    RUN    = 4'b0100,
    KEYFWD = 4'b1100
  } state_t;

  state_t         state;
  logic [KW-1:0]  key;
  logic [KW-1:0]  win;
  logic [BW-1:0]  blk;
  logic [3:0]     bcnt;
  logic [5:0]     rcnt;
  logic           dec_q;
  logic           dec_req;

  logic [N-1:0]   x, y, nx, rkey, fwd_top;
  logic [KW-1:0]  fwd_win, nxt_win;

`ifdef SIMON_DECRYPT_EN
  logic [N-1:0]   inv_w0;
  logic [5:0]     zi_inv;
  assign dec_req = in_decrypt;
`else
  assign dec_req = in_decrypt & 1'b0;
`endif

  always_comb begin
    x       = blk[BW-1:N];
    y       = blk[N-1:0];
    fwd_top = ~win[N-1:0] ^ kt(win[KW-1 -: N], win[2*N-1 -: N]) ^ N'(ZSEQ[rcnt]) ^ N'(3);
    fwd_win = {fwd_top, win[KW-1:N]};
`ifdef SIMON_DECRYPT_EN
    // Inverse step recovers the word the forward step consumed, using z of that step.
    zi_inv  = RLAST - rcnt;
    inv_w0  = ~(win[KW-1 -: N] ^ kt(win[KW-N-1 -: N], win[N-1:0]) ^ N'(ZSEQ[zi_inv]) ^ N'(3));
    rkey    = dec_q ? inv_w0 : win[N-1:0];
    nxt_win = dec_q ? {win[KW-N-1:0], inv_w0} : fwd_win;
`else
    rkey    = win[N-1:0];
    nxt_win = fwd_win;
`endif
    nx      = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rkey;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      key   <= '0;
      win   <= '0;
      blk   <= '0;
      bcnt  <= '0;
      rcnt  <= '0;
      dec_q <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid && in_is_key) begin
            key <= {key[KW-9:0], in_data};
          end else if (in_valid) begin
            blk <= {blk[BW-9:0], in_data};
            if (bcnt == BLAST) begin
              bcnt  <= '0;
              rcnt  <= '0;
              win   <= key;
              dec_q <= dec_req;
              state <= dec_req ? KEYFWD : RUN;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
`ifdef SIMON_DECRYPT_EN
        KEYFWD: begin
          win <= fwd_win;
          if (rcnt == RLAST) begin
            rcnt  <= '0;
            blk   <= {y, x};
            state <= RUN;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
`endif
        RUN: begin
          win <= nxt_win;
          if (rcnt == RLAST) begin
            rcnt  <= '0;
            blk   <= dec_q ? {x, nx} : {nx, x};
            state <= OUT;
          end else begin
            rcnt <= rcnt + 1'b1;
            blk  <= {nx, x};
          end
        end
        OUT: begin
          if (out_ready) begin
            blk <= {blk[BW-9:0], 8'h00};
            if (bcnt == BLAST) begin
              bcnt  <= '0;
              state <= LOAD;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = state[0];
  assign out_valid = state[1];
  assign busy      = state[2];
  assign out_data  = blk[BW-1 -: 8];

endmodule

// File: tb/tb_simon_byte_engine.sv
// Directed scoreboard bench for simon_byte_engine: Simon32/64 and Simon64/96 instances.
module tb_simon_byte_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_data_s [2];
  logic in_valid_s [2];
  logic in_is_key_s [2];
  logic in_decrypt_s [2];
  logic out_ready_s [2];
  logic rdy_a, ov_a, busy_a, rdy_b, ov_b, busy_b;
  logic [7:0] od_a, od_b;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  logic [7:0] sb [$];

  localparam logic [63:0] KEY16 = 64'h1918111009080100;

  always #5 clk = ~clk;

  simon_byte_engine #(.N(16), .M(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_is_key(in_is_key_s[0]),
    .in_decrypt(in_decrypt_s[0]), .in_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready_s[0]), .busy(busy_a)
  );

  simon_byte_engine #(.N(32), .M(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_is_key(in_is_key_s[1]),
    .in_decrypt(in_decrypt_s[1]), .in_ready(rdy_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready_s[1]), .busy(busy_b)
  );

  function automatic logic f_rdy(input int unsigned d);
    return (d != 0) ? rdy_b : rdy_a;
  endfunction
  function automatic logic f_ov(input int unsigned d);
    return (d != 0) ? ov_b : ov_a;
  endfunction
  function automatic logic f_busy(input int unsigned d);
    return (d != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic [7:0] f_od(input int unsigned d);
    return (d != 0) ? od_b : od_a;
  endfunction

  // Reference Simon32/64 encryption with the textbook key expansion.
  function automatic logic [31:0] simon32_enc(input logic [63:0] k64, input logic [31:0] pt);
    logic [15:0] k [32];
    logic [15:0] xv, yv, t, tmp;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = {k[i-1][2:0], k[i-1][15:3]};
      t = t ^ k[i-3];
      t = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    xv = pt[31:16];
    yv = pt[15:0];
    for (int r = 0; r < 32; r++) begin
      tmp = xv;
      xv = yv ^ (({xv[14:0], xv[15]} & {xv[7:0], xv[15:8]}) ^ {xv[13:0], xv[15:14]}) ^ k[r];
      yv = tmp;
    end
    return {xv, yv};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int unsigned d, input logic [7:0] b, input logic k, input logic dec);
    int unsigned n = 0;
    @(negedge clk);
    in_valid_s[d] = 1'b1;
    in_data_s[d] = b;
    in_is_key_s[d] = k;
    in_decrypt_s[d] = dec;
    while (!f_rdy(d) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!f_rdy(d)) check("in_ready_wait", 64'(f_rdy(d)), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int unsigned d, input logic [95:0] kv, input int unsigned nbytes);
    for (int i = int'(nbytes) - 1; i >= 0; i--) drive(d, kv[8*i +: 8], 1'b1, 1'b0);
    in_valid_s[d] = 1'b0;
  endtask

  task automatic load_block(input int unsigned d, input logic [63:0] v, input int unsigned nbytes,
                            input logic dec);
    for (int i = int'(nbytes) - 1; i >= 0; i--) drive(d, v[8*i +: 8], 1'b0, dec);
    in_valid_s[d] = 1'b0;
    in_decrypt_s[d] = 1'b0;
  endtask

  task automatic push_expect(input logic [63:0] v, input int unsigned nbytes);
    for (int i = int'(nbytes) - 1; i >= 0; i--) sb.push_back(v[8*i +: 8]);
  endtask

  // Called right after the final block byte is accepted.
  task automatic measure(input int unsigned d, input int unsigned exp_lat, input int unsigned exp_busy,
                         input string tag);
    int unsigned lat = 0;
    int unsigned bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (f_busy(d)) bc++;
    end while (!f_ov(d) && lat < 300);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
  endtask

  task automatic collect(input int unsigned d, input int unsigned nbytes, input bit bp, input string tag);
    int unsigned cyc = 0;
    int unsigned got = 0;
    int unsigned ovc = 0;
    while (got < nbytes && cyc < 2000) begin
      @(negedge clk);
      if (bp) begin
        out_ready_s[d] = f_ov(d) && (ovc >= 10) && ovc[0];
        in_valid_s[d] = 1'($urandom_range(0, 1));
        in_is_key_s[d] = 1'($urandom_range(0, 1));
        in_data_s[d] = 8'($urandom);
      end else begin
        out_ready_s[d] = 1'b1;
      end
      if (f_ov(d)) begin
        ovc++;
        if (sb.size() == 0) begin
          check({tag, "_unexpected_byte"}, 64'(f_ov(d)), 64'd0);
        end else begin
          check({tag, "_byte"}, 64'(f_od(d)), 64'(sb[0]));
          if (out_ready_s[d]) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    out_ready_s[d] = 1'b0;
    in_valid_s[d] = 1'b0;
    in_is_key_s[d] = 1'b0;
    check({tag, "_bytes_accepted"}, 64'(got), 64'(nbytes));
  endtask

  // Cycle right after the last output byte: back in LOAD with an empty block.
  task automatic post_out(input int unsigned d, input string tag);
    check({tag, "_post_in_ready"}, 64'(f_rdy(d)), 64'd1);
    check({tag, "_post_out_valid"}, 64'(f_ov(d)), 64'd0);
    check({tag, "_post_out_data"}, 64'(f_od(d)), 64'd0);
  endtask

  initial begin
    logic [31:0] pt;
    for (int i = 0; i < 2; i++) begin
      in_data_s[i] = 8'h00;
      in_valid_s[i] = 1'b0;
      in_is_key_s[i] = 1'b0;
      in_decrypt_s[i] = 1'b0;
      out_ready_s[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned d = 0; d < 2; d++) begin
      check("reset_in_ready", 64'(f_rdy(d)), 64'd1);
      check("reset_out_valid", 64'(f_ov(d)), 64'd0);
      check("reset_busy", 64'(f_busy(d)), 64'd0);
      check("reset_out_data", 64'(f_od(d)), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Simon32/64 reference vector
    load_key(0, 96'(KEY16), 8);
    load_block(0, 64'h65656877, 4, 1'b0);
    push_expect(64'hc69be9bb, 4);
    measure(0, 33, 32, "enc16");
    collect(0, 4, 1'b0, "enc16");
    post_out(0, "enc16");

    // Same key, second direction (or encrypt with in_decrypt ignored)
`ifdef SIMON_DECRYPT_EN
    load_block(0, 64'hc69be9bb, 4, 1'b1);
    push_expect(64'h65656877, 4);
    measure(0, 65, 64, "dec16");
    collect(0, 4, 1'b0, "dec16");
    post_out(0, "dec16");
`else
    load_block(0, 64'h65656877, 4, 1'b1);
    push_expect(64'hc69be9bb, 4);
    measure(0, 33, 32, "nodec16");
    collect(0, 4, 1'b0, "nodec16");
    post_out(0, "nodec16");
`endif

    // Simon64/96 reference vector
    load_key(1, 96'h131211100b0a090803020100, 12);
    load_block(1, 64'h6f7220676e696c63, 8, 1'b0);
    push_expect(64'h5ca2e27f111a8fc8, 8);
    measure(1, 43, 42, "enc32");
    collect(1, 8, 1'b0, "enc32");
    post_out(1, "enc32");

    // Backpressure with junk on the load port outside LOAD
    pt = $urandom;
    load_block(0, 64'(pt), 4, 1'b0);
    push_expect(64'(simon32_enc(KEY16, pt)), 4);
    collect(0, 4, 1'b1, "bp16");
    post_out(0, "bp16");
    pt = $urandom;
    load_block(0, 64'(pt), 4, 1'b0);
    push_expect(64'(simon32_enc(KEY16, pt)), 4);
    measure(0, 33, 32, "after_bp16");
    collect(0, 4, 1'b0, "after_bp16");

    // Reset in the middle of RUN
    load_block(0, 64'h12345678, 4, 1'b0);
    repeat (10) @(negedge clk);
    check("midrun_busy", 64'(f_busy(0)), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_rst_in_ready", 64'(f_rdy(0)), 64'd1);
    check("midrun_rst_busy", 64'(f_busy(0)), 64'd0);
    check("midrun_rst_out_valid", 64'(f_ov(0)), 64'd0);
    check("midrun_rst_out_data", 64'(f_od(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Extra leading key byte must be shifted out by the last eight
    load_key(0, 96'hAA_0000000000000000, 9);
    load_block(0, 64'h65656877, 4, 1'b0);
    push_expect(64'(simon32_enc(64'h0, 32'h65656877)), 4);
    measure(0, 33, 32, "zerokey16");
    collect(0, 4, 1'b0, "zerokey16");
    post_out(0, "zerokey16");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
